// File: rtl/bcd_key_entry.sv
// Operand entry front-end: button synchronise/debounce, 4-digit BCD editor
// with cursor, and a valid/ready hand-off of the binary operand to the CPU.
module bcd_key_entry #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_c,
  input  logic        start_ready,
  input  logic        cpu_busy,
  output logic [15:0] seg_data_16,
  output logic [1:0]  cursor,
  output logic        start_valid,
  output logic [13:0] operand_bin,
  output logic [1:0]  entry_state
);

  // state | meaning
  // EDIT  | buttons edit digits / move cursor, C submits
  // REQ   | operand offered to CPU, waiting for start_ready
  // LOCK  | CPU computing, editing locked until cpu_busy drops
  typedef enum logic [1:0] {
    ST_EDIT = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit order: 0 = U, 1 = D, 2 = L, 3 = R, 4 = C
  logic [4:0]    btn_raw;
  logic [4:0]    sync_q1, sync_q2;
  logic [4:0]    deb_lvl, deb_q;
  logic [4:0]    press;
  logic [CW-1:0] deb_cnt [5];

  state_t        state;
  logic [3:0]    digit [4];

  assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Per-button debounce: level flips only after a run of stable differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_q2[i] != deb_lvl[i]) begin
          if (deb_cnt[i] == CNT_LAST) begin
            deb_lvl[i] <= sync_q2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Edge register for rising-edge press detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb_q <= '0;
    else        deb_q <= deb_lvl;
  end

  assign press = deb_lvl & ~deb_q;

  // Entry FSM with registered digits, cursor, handshake and operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EDIT;
      cursor      <= 2'd0;
      start_valid <= 1'b0;
      operand_bin <= '0;
      for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
    end else begin
      case (state)
        ST_EDIT: begin
          if (press[4]) begin
            operand_bin <= {10'd0, digit[3]} * 14'd1000
                         + {10'd0, digit[2]} * 14'd100
                         + {10'd0, digit[1]} * 14'd10
                         + {10'd0, digit[0]};
            start_valid <= 1'b1;
            state       <= ST_REQ;
          end else if (press[0]) begin
            digit[cursor] <= (digit[cursor] >= 4'd9) ? 4'd0 : digit[cursor] + 4'd1;
          end else if (press[1]) begin
            digit[cursor] <= (digit[cursor] == 4'd0) ? 4'd9 : digit[cursor] - 4'd1;
          end else if (press[2]) begin
            cursor <= cursor + 2'd1;
          end else if (press[3]) begin
            cursor <= cursor - 2'd1;
          end
        end
        ST_REQ: begin
          if (start_ready) begin
            start_valid <= 1'b0;
            state       <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (!cpu_busy) state <= ST_EDIT;
        end
        default: begin
          start_valid <= 1'b0;
          state       <= ST_EDIT;
        end
      endcase
    end
  end

  assign seg_data_16 = {digit[3], digit[2], digit[1], digit[0]};
  assign entry_state = state;

endmodule

// File: doc/bcd_key_entry.md
# bcd_key_entry

Operand entry front-end for the Basys3 GCD demo. Debounces the five push-buttons, lets the user edit a 4-digit BCD operand with a cursor, and drives the packed digits to the seven-segment display driver. On the centre button it hands the binary value of the operand to the CPU through a valid/ready handshake, then locks editing while the CPU computes.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable clk cycles (10 ms at 100 MHz) required to accept a button level change. Legal range is ≥ 2. The counter width is derived internally as `$clog2(DEBOUNCE_CYCLES+1)`.
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_u`, `btn_d`, `btn_l`, `btn_r`, `btn_c` in 1 each: raw, asynchronous, active-high buttons.
- `start_ready` in 1: CPU accepts the operand.
- `cpu_busy` in 1: CPU is computing.
- `seg_data_16` out 16: packed BCD digits, `[15:12]` = d3 (MSD) … `[3:0]` = d0.
- `cursor` out 2: index of the digit being edited (0 = d0).
- `start_valid` out 1: operand offered to the CPU.
- `operand_bin` out 14: binary value d3·1000 + d2·100 + d1·10 + d0. Range 0..9999.
- `entry_state` out 2: 0 = EDIT, 1 = REQ, 2 = LOCK.

## Operation
- **Synchroniser.** Each button passes through a 2-flop synchroniser.
- **Debounce.** Each button has its own counter and a debounced level register.
  - While the synchronised value differs from the debounced level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES−1 while still differing, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- **Press event.** A single-cycle pulse on the 0→1 transition of a debounced level. Holding a button produces exactly one event.
- **Priority.** When several events occur in one cycle, only one is serviced, in the order C > U > D > L > R. The others are discarded.
- **FSM state EDIT.** Events are serviced as follows:
  - U: digit[cursor] = (digit + 1) mod 10, so 9 → 0.
  - D: digit[cursor] = (digit − 1) mod 10, so 0 → 9.
  - L: cursor = cursor + 1, wrapping 3 → 0.
  - R: cursor = cursor − 1, wrapping 0 → 3.
  - C: latch `operand_bin` from the current digits, then go to REQ.
- **FSM state REQ.**
  - `start_valid` = 1, and `operand_bin` is held stable.
  - All button events are ignored.
  - In a cycle where `start_valid` && `start_ready`, go to LOCK.
- **FSM state LOCK.**
  - Events are ignored.
  - In the first cycle with `cpu_busy` = 0, go to EDIT.
  - Digits and cursor are retained, so the operand can be re-edited.
- **CPU contract.** The CPU asserts `cpu_busy` in the cycle after acceptance and holds it until the result is valid.
- **Digit conversion.** `operand_bin` is computed with 14-bit unsigned arithmetic and registered on the C event. It holds its value in all other cycles.
- **Digit legality.** Digits are always BCD 0..9; no illegal code is ever produced.

## Timing
- **Reset values.**
  - `seg_data_16` = 16'h0000, `cursor` = 0, `start_valid` = 0, `operand_bin` = 0, `entry_state` = 0 (EDIT).
  - All synchronisers, debounce counters, debounced levels and edge registers = 0.
- **Reset mid-operation.** Reset asserted at any time, including mid-debounce or in REQ, returns immediately to the reset values. A button still held after reset release yields one event after 2 + DEBOUNCE_CYCLES cycles.
- **Press latency.** From a clean raw edge to the press-event pulse is 2 (sync) + DEBOUNCE_CYCLES cycles.
- **Event response.** For a press event in cycle N:
  - `seg_data_16` or `cursor` updates at N+1.
  - For C: `start_valid` = 1 and `operand_bin` are valid at N+1, and `entry_state` = 1 at N+1.
- **Handshake.** For `start_valid` && `start_ready` in cycle M:
  - `start_valid` = 0 and `entry_state` = 2 at M+1.
  - If `start_ready` is already high at N+1, the transfer completes in one cycle.
- **LOCK exit.** `cpu_busy` = 0 in cycle K (while in LOCK) gives `entry_state` = 0 at K+1. Events in cycle K are discarded.
- **Outputs.** All outputs are registered; there are no combinational input-to-output paths.

## Test plan
Run with DEBOUNCE_CYCLES = 4.
- **Bounce filter.** Reset, then toggle `btn_u` every 2 cycles for 20 cycles, then hold it high for 10 cycles. Required: exactly one increment, `seg_data_16` = 16'h0001, `cursor` = 0.
- **Digit and cursor wrap.**
  - At cursor 0, press D once: d0 = 9 (`seg_data_16` = 16'h0009).
  - Press U: d0 = 0.
  - Press R from cursor 0: `cursor` = 3.
  - Press L: `cursor` = 0.
- **Entry and handshake.**
  - Enter digits 1,2,3,4 (d3..d0), press C with `start_ready` = 0 for 5 cycles. Required: `start_valid` = 1, `operand_bin` = 1234, `entry_state` = 1, stable throughout.
  - Raise `start_ready` for one cycle. Required: `start_valid` = 0 and `entry_state` = 2 at the next cycle.
- **Lock.** With `cpu_busy` = 1, press U, L and C. Required: no change to digits, cursor or `start_valid`. Drop `cpu_busy`: `entry_state` = 0 one cycle later.
- **Simultaneous events.** Press `btn_u` and `btn_l` on the same cycle. Required: only the increment occurs, `cursor` unchanged. Then press `btn_c` and `btn_u` together: REQ with the digits unchanged.
- **Reset in REQ.** Assert `rst_n` = 0 while `start_valid` = 1. Required: all outputs return to reset values asynchronously; `operand_bin` = 0.
